// File: rtl/dma_port_arbiter.sv
// dma_port_arbiter: shares the single DMA/RAM byte port between two requesters.
// Grants one transaction at a time with round-robin priority, holds the DMA
// strobe until the matching done, then pulses a one-cycle ack (with read data)
// back to the winner. Every output is driven straight from a flop.
//
// Optional feature macro: DMA_TIMEOUT_EN
//   defined   -> a transfer with no matching done after TIMEOUT XFER cycles is
//                aborted and acked with err = 1.
//   undefined -> no counter, err is constant 0, XFER waits indefinitely.
module dma_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              RST,
  // Requester 0
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  // Requester 1
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  // DMA port
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_wdata,
  output logic              dma_rd,
  output logic              dma_wr,
  input  logic [DATA_W-1:0] dma_rdata,
  input  logic              dma_done_rd,
  input  logic              dma_done_wr,
  // Status
  output logic              busy,
  output logic              err,
  output logic              last_gnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StAck  = 2'd2
  } arbState;

  arbState stateQ, stateD;

  logic [1:0]        gntQ, gntD;
  logic [1:0]        ackQ, ackD;
  logic [DATA_W-1:0] rdata0Q, rdata0D;
  logic [DATA_W-1:0] rdata1Q, rdata1D;
  logic [ADDR_W-1:0] dmaAddrQ, dmaAddrD;
  logic [DATA_W-1:0] dmaWdataQ, dmaWdataD;
  logic              dmaRdQ, dmaRdD;
  logic              dmaWrQ, dmaWrD;
  logic              busyQ, busyD;
  logic              errQ, errD;
  logic              lastGntQ, lastGntD;
  // Latched direction and owner of the transaction in flight.
  logic              weQ, weD;
  logic              ownerQ, ownerD;
  // Requester preferred on a tie; separate from last_gnt so that requester 0
  // wins the first tie after reset even though last_gnt also resets to 0.
  logic              prefQ, prefD;

  logic              winner;
  logic              doneMatch;

`ifdef DMA_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  logic [CntW-1:0] cntQ, cntD;
  logic [CntW-1:0] cntInc;

  assign cntInc = cntQ + 1'b1;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT == 0);
`endif

  // Completion only counts for the done that matches the latched direction.
  assign doneMatch = weQ ? dma_done_wr : dma_done_rd;

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RST) begin
      stateQ    <= StIdle;
      gntQ      <= 2'b00;
      ackQ      <= 2'b00;
      rdata0Q   <= '0;
      rdata1Q   <= '0;
      dmaAddrQ  <= '0;
      dmaWdataQ <= '0;
      dmaRdQ    <= 1'b0;
      dmaWrQ    <= 1'b0;
      busyQ     <= 1'b0;
      errQ      <= 1'b0;
      lastGntQ  <= 1'b0;
      weQ       <= 1'b0;
      ownerQ    <= 1'b0;
      prefQ     <= 1'b0;
`ifdef DMA_TIMEOUT_EN
      cntQ      <= '0;
`endif
    end else begin
      stateQ    <= stateD;
      gntQ      <= gntD;
      ackQ      <= ackD;
      rdata0Q   <= rdata0D;
      rdata1Q   <= rdata1D;
      dmaAddrQ  <= dmaAddrD;
      dmaWdataQ <= dmaWdataD;
      dmaRdQ    <= dmaRdD;
      dmaWrQ    <= dmaWrD;
      busyQ     <= busyD;
      errQ      <= errD;
      lastGntQ  <= lastGntD;
      weQ       <= weD;
      ownerQ    <= ownerD;
      prefQ     <= prefD;
`ifdef DMA_TIMEOUT_EN
      cntQ      <= cntD;
`endif
    end
  end

  // Next-state and next-output logic for the IDLE/XFER/ACK arbiter.
  always_comb begin
    stateD    = stateQ;
    gntD      = gntQ;
    ackD      = 2'b00;
    rdata0D   = rdata0Q;
    rdata1D   = rdata1Q;
    dmaAddrD  = dmaAddrQ;
    dmaWdataD = dmaWdataQ;
    dmaRdD    = dmaRdQ;
    dmaWrD    = dmaWrQ;
    busyD     = busyQ;
    errD      = 1'b0;
    lastGntD  = lastGntQ;
    weD       = weQ;
    ownerD    = ownerQ;
    prefD     = prefQ;
    winner    = 1'b0;
`ifdef DMA_TIMEOUT_EN
    cntD      = cntQ;
`endif

    unique case (stateQ)
      StIdle: begin
        if (req0 || req1) begin
          // Tie goes to the preferred requester; otherwise the lone requester.
          winner       = (req0 && req1) ? prefQ : req1;
          ownerD       = winner;
          weD          = winner ? we1 : we0;
          dmaAddrD     = winner ? addr1 : addr0;
          dmaWdataD    = winner ? wdata1 : wdata0;
          dmaWrD       = weD;
          dmaRdD       = !weD;
          gntD         = 2'b00;
          gntD[winner] = 1'b1;
          busyD        = 1'b1;
`ifdef DMA_TIMEOUT_EN
          cntD         = '0;
`endif
          stateD       = StXfer;
        end
      end

      StXfer: begin
        if (doneMatch) begin
          dmaRdD       = 1'b0;
          dmaWrD       = 1'b0;
          if (!weQ) begin
            if (ownerQ) rdata1D = dma_rdata;
            else        rdata0D = dma_rdata;
          end
          ackD[ownerQ] = 1'b1;
          lastGntD     = ownerQ;
          prefD        = !ownerQ;
          stateD       = StAck;
        end
`ifdef DMA_TIMEOUT_EN
        else if (cntInc == TimeoutCnt) begin
          // Abort: ack with err, read data left untouched.
          dmaRdD       = 1'b0;
          dmaWrD       = 1'b0;
          ackD[ownerQ] = 1'b1;
          errD         = 1'b1;
          lastGntD     = ownerQ;
          prefD        = !ownerQ;
          stateD       = StAck;
        end else begin
          cntD = cntInc;
        end
`endif
      end

      StAck: begin
        gntD   = 2'b00;
        busyD  = 1'b0;
        stateD = StIdle;
      end

      default: begin
        gntD   = 2'b00;
        busyD  = 1'b0;
        dmaRdD = 1'b0;
        dmaWrD = 1'b0;
        stateD = StIdle;
      end
    endcase
  end

  assign gnt0      = gntQ[0];
  assign gnt1      = gntQ[1];
  assign ack0      = ackQ[0];
  assign ack1      = ackQ[1];
  assign rdata0    = rdata0Q;
  assign rdata1    = rdata1Q;
  assign dma_addr  = dmaAddrQ;
  assign dma_wdata = dmaWdataQ;
  assign dma_rd    = dmaRdQ;
  assign dma_wr    = dmaWrQ;
  assign busy      = busyQ;
  assign err       = errQ;
  assign last_gnt  = lastGntQ;

  gntOneHot: assert property (@(posedge clk) !(gntQ[0] && gntQ[1]));
  ackOneHot: assert property (@(posedge clk) !(ackQ[0] && ackQ[1]));
  strobeOneHot: assert property (@(posedge clk) !(dmaRdQ && dmaWrQ));

endmodule

// File: doc/dma_port_arbiter.md
Name: dma_port_arbiter

Overview:
Shares the single DMA/RAM byte port between two requesters, typically the file loader (writes) and the convolution engine (reads).
- Grants one transaction at a time using round-robin priority.
- Latches the winner's command and drives the DMA read/write strobes until the DMA reports completion.
- Returns a one-cycle acknowledge, with read data, to the winning requester.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, RAM data width
TIMEOUT, 255, cycles allowed in XFER before abort (only with DMA_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
RST  in  1  reset; synchronous, active-low
req0  in  1  requester 0 transaction request, held until ack0
we0  in  1  requester 0 direction: 1 = write, 0 = read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write byte
gnt0  out  1  requester 0 owns the port (XFER/ACK)
ack0  out  1  one-cycle completion pulse to requester 0
rdata0  out  DATA_W  read byte for requester 0, valid with ack0 and held after
req1, we1, addr1, wdata1, gnt1, ack1, rdata1: same as above, for requester 1
dma_addr  out  ADDR_W  address to DMA
dma_wdata  out  DATA_W  write byte to DMA
dma_rd  out  1  DMA read strobe, level
dma_wr  out  1  DMA write strobe, level
dma_rdata  in  DATA_W  DMA read data, valid with dma_done_rd
dma_done_rd  in  1  DMA read complete
dma_done_wr  in  1  DMA write complete
busy  out  1  high whenever state is not IDLE
err  out  1  one-cycle timeout flag, coincident with ack
last_gnt  out  1  index of the last requester served

Behaviour:
- Reset (RST low at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: gnt*, ack*, rdata*, dma_*, busy, err, last_gnt.
  - Round-robin pointer resets so requester 0 is preferred.
  - Any in-flight DMA transaction is abandoned; no ack is issued for it.
- Registered outputs: every output is registered; no combinational path from any input to any output.
- FSM states: IDLE, XFER, ACK.
- IDLE:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester != last_gnt wins (after reset, requester 0).
  - On a win: latch addr, wdata and we into dma_addr, dma_wdata and the direction register; set gnt_n = 1, busy = 1; set dma_wr = we_n and dma_rd = !we_n; go to XFER.
  - Strobes rise on the edge after req is sampled (1-cycle grant latency).
- XFER:
  - Strobes are held.
  - Completion is the done signal matching the latched direction: dma_done_wr for writes, dma_done_rd for reads. The opposite done is ignored.
  - On completion: drop the strobe, capture dma_rdata into rdata_n (reads only; writes leave rdata_n unchanged), set ack_n = 1, update last_gnt = n, go to ACK.
- ACK:
  - ack_n is cleared.
  - gnt_n and busy are cleared.
  - Go to IDLE.
  - A new request is accepted in IDLE on the following edge, so the minimum transaction is 4 cycles when done arrives one cycle after the strobe.
- Requester rules:
  - Requester inputs are sampled only in IDLE; changes to req, addr or wdata during XFER/ACK are ignored.
  - Dropping req mid-transfer does not cancel; the transfer completes and the ack is still pulsed.
  - A requester still holding req after its own ack re-competes in IDLE; round-robin gives the other requester priority if it is also requesting.
- Done in IDLE or ACK is ignored.
- Outputs are one-hot: at most one of gnt0/gnt1 and at most one of ack0/ack1 is high at any time.

Optional Feature:
DMA_TIMEOUT_EN:
- Defined:
  - An 8-bit-or-wider counter clears on entering XFER and increments each XFER cycle.
  - When the counter reaches TIMEOUT without a matching done: drop the strobe, pulse ack_n with err = 1 for one cycle, leave rdata_n unchanged, update last_gnt, go to ACK.
  - If done and the timeout coincide, done wins and err = 0.
- Undefined: no counter exists, err is constant 0, and XFER waits indefinitely.

Test Plan:
1. Reset, then req0 = 1, we0 = 1, addr0 = 0x0100, wdata0 = 0xA5; DMA asserts done_wr 2 cycles after dma_wr -> dma_wr high 2 cycles with dma_addr = 0x0100 and dma_wdata = 0xA5; ack0 pulses once; gnt1 and ack1 stay 0.
2. req1 read at addr1 = 0x0200; DMA returns dma_rdata = 0x3C with done_rd -> rdata1 = 0x3C with ack1; dma_wr never high.
3. req0 and req1 held high together for 4 transactions, right after reset -> grant order 0,1,0,1; last_gnt toggles each ack.
4. During requester 0's XFER: assert done_rd on a write and change addr0 to 0x0FFF -> transfer continues; completes only on done_wr, with dma_addr still the originally latched value.
5. Drive RST low for 1 cycle mid-XFER -> all outputs 0 next cycle, no ack; a subsequent req0 read to 0x0010 is granted normally.
6. With DMA_TIMEOUT_EN and TIMEOUT = 4: request with no done -> strobe drops after 4 XFER cycles; ack and err pulse together. Without the macro -> err stays 0 and busy stays high.
